// File: rtl/scb_pkg.sv
// scb_pkg: shared defaults and helpers for the register scoreboard.
//   DEF_NUM_REGS : default number of architectural registers tracked
//   DEF_MAX_PEND : default maximum in-flight writes per register
//   clog2        : ceiling log2, never returns less than 1
//   DEF_CNT_W    : pending-counter width for DEF_MAX_PEND
package scb_pkg;

    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_MAX_PEND = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    localparam int unsigned DEF_CNT_W = clog2(DEF_MAX_PEND + 1);

endpackage

// File: rtl/scb_counter.sv
// scb_counter: one saturating up/down pending-write counter.
//   clk   in  : clock
//   reset in  : synchronous active-high reset, clears the counter
//   clear in  : flush, clears the counter (discards same-cycle inc/dec)
//   inc   in  : one write issued to this register
//   dec   in  : one write retired from this register
//   cnt   out : current pending count (registered)
module scb_counter
    import scb_pkg::*;
#(
    parameter int unsigned MAX_PEND = DEF_MAX_PEND,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; both ends saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and gates instruction issue.
//   clk, reset            : clock, synchronous active-high reset
//   id_valid              : decode presents an instruction
//   id_src1/id_src2       : source register addresses
//   id_dst, id_dst_we     : destination address and write enable
//   id_ready              : instruction may issue this cycle (combinational)
//   wb_valid, wb_addr     : writeback retires one write
//   flush                 : discard all in-flight tracking
//   pend_vec              : per-register "counter nonzero" flags
//   inflight              : total outstanding writes
//   stall_cycles          : saturating count of stalled decode cycles
//   err_underflow         : sticky, retire seen with no pending write
// Optional feature: define SCB_RETIRE_BYPASS_EN to let a same-cycle retire of
// the last pending write clear the source hazard on that register.
module reg_scoreboard
    import scb_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned MAX_PEND = DEF_MAX_PEND,
    parameter int unsigned ADDR_W   = clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_src1,
    input  logic [ADDR_W-1:0]   id_src2,
    input  logic [ADDR_W-1:0]   id_dst,
    input  logic                id_dst_we,
    output logic                id_ready,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pend_vec,
    output logic [7:0]          inflight,
    output logic [15:0]         stall_cycles,
    output logic                err_underflow
);

    localparam int unsigned      CNT_W   = clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            issue_vec;
    logic [NUM_REGS-1:0]            retire_vec;

    logic [CNT_W-1:0] src1_cnt, src2_cnt, dst_cnt, wb_cnt;
    logic             dst_hit, wb_hit;
    logic             byp1, byp2, haz1, haz2, waw;
    logic             do_issue, do_retire, same_reg;

    logic [7:0]  inflight_q, inflight_d;
    logic [15:0] stall_q, stall_d;
    logic        err_q, err_d;

    // Register 0 is never tracked; only indices 1..NUM_REGS-1 have counters.
    assign cnt[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        scb_counter #(
            .MAX_PEND (MAX_PEND),
            .CNT_W    (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .inc   (issue_vec[g]),
            .dec   (retire_vec[g]),
            .cnt   (cnt[g])
        );
    end

    // Address lookups; out-of-range or zero addresses read as count 0 / no hit.
    always_comb begin
        src1_cnt = '0;
        src2_cnt = '0;
        dst_cnt  = '0;
        wb_cnt   = '0;
        dst_hit  = 1'b0;
        wb_hit   = 1'b0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (id_src1 == ADDR_W'(i)) src1_cnt = cnt[i];
            if (id_src2 == ADDR_W'(i)) src2_cnt = cnt[i];
            if (id_dst == ADDR_W'(i)) begin
                dst_cnt = cnt[i];
                dst_hit = 1'b1;
            end
            if (wb_addr == ADDR_W'(i)) begin
                wb_cnt = cnt[i];
                wb_hit = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef SCB_RETIRE_BYPASS_EN
        byp1 = wb_valid && (wb_addr == id_src1) && (src1_cnt == CNT_ONE);
        byp2 = wb_valid && (wb_addr == id_src2) && (src2_cnt == CNT_ONE);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        haz1      = (src1_cnt != '0) && !byp1;
        haz2      = (src2_cnt != '0) && !byp2;
        waw       = id_dst_we && dst_hit && (dst_cnt == CNT_MAX);
        id_ready  = !(haz1 || haz2 || waw) && !flush;
        do_issue  = id_valid && id_ready && id_dst_we && dst_hit;
        do_retire = wb_valid && wb_hit && !flush;
        same_reg  = do_issue && do_retire && (id_dst == wb_addr);
    end

    always_comb begin
        issue_vec  = '0;
        retire_vec = '0;
        pend_vec   = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            issue_vec[i]  = do_issue && (id_dst == ADDR_W'(i));
            retire_vec[i] = do_retire && (wb_addr == ADDR_W'(i));
            pend_vec[i]   = (cnt[i] != '0);
        end
    end

    // inflight mirrors the counters: a same-register issue/retire pair nets
    // zero, and a retire against an empty counter changes nothing but err.
    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else begin
            if (do_issue && !same_reg)
                inflight_d = inflight_d + 8'd1;
            if (do_retire && !same_reg && (wb_cnt != '0))
                inflight_d = inflight_d - 8'd1;
        end
        err_d   = err_q || (do_retire && !same_reg && (wb_cnt == '0));
        stall_d = stall_q;
        if (id_valid && !id_ready && (stall_q != '1))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign inflight      = inflight_q;
    assign stall_cycles  = stall_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard
// (NUM_REGS=32, MAX_PEND=3). Expected values are hand-computed constants;
// the retire-bypass variant is selected by SCB_RETIRE_BYPASS_EN.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_src1 = '0;
    logic [4:0]  id_src2 = '0;
    logic [4:0]  id_dst = '0;
    logic        id_dst_we = 1'b0;
    logic        id_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] pend_vec;
    logic [7:0]  inflight;
    logic [15:0] stall_cycles;
    logic        err_underflow;

    int vectors = 0;
    int miscompares = 0;

`ifdef SCB_RETIRE_BYPASS_EN
    localparam logic [31:0] EXP_BYP_READY = 32'd1;
    localparam logic [31:0] S0            = 32'd0;
`else
    localparam logic [31:0] EXP_BYP_READY = 32'd0;
    localparam logic [31:0] S0            = 32'd1;
`endif

    reg_scoreboard #(
        .NUM_REGS (32),
        .MAX_PEND (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_dst        (id_dst),
        .id_dst_we     (id_dst_we),
        .id_ready      (id_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .flush         (flush),
        .pend_vec      (pend_vec),
        .inflight      (inflight),
        .stall_cycles  (stall_cycles),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_pend",  pend_vec, 32'h0);
        chk("rst_infl",  {24'h0, inflight}, 32'h0);
        chk("rst_stall", {16'h0, stall_cycles}, 32'h0);
        chk("rst_err",   {31'h0, err_underflow}, 32'h0);
        chk("rst_ready", {31'h0, id_ready}, 32'h1);

        // RAW hazard on r5 and its release by writeback
        id_valid = 1'b1; id_dst_we = 1'b1; id_dst = 5'd5;
        #1 chk("r5_issue_ready", {31'h0, id_ready}, 32'h1);
        cyc();
        id_dst_we = 1'b0; id_dst = 5'd0; id_src1 = 5'd5;
        #1 chk("r5_raw_ready", {31'h0, id_ready}, 32'h0);
        chk("r5_pend", pend_vec, 32'h20);
        chk("r5_infl", {24'h0, inflight}, 32'h1);
        wb_valid = 1'b1; wb_addr = 5'd5;
        #1 chk("r5_byp_ready", {31'h0, id_ready}, EXP_BYP_READY);
        cyc();
        wb_valid = 1'b0; wb_addr = 5'd0;
        #1 chk("r5_after_ready", {31'h0, id_ready}, 32'h1);
        chk("r5_after_pend", pend_vec, 32'h0);
        chk("r5_after_infl", {24'h0, inflight}, 32'h0);
        chk("r5_stall", {16'h0, stall_cycles}, S0);
        id_valid = 1'b0; id_src1 = 5'd0;

        // WAW limit on r7
        id_valid = 1'b1; id_dst_we = 1'b1; id_dst = 5'd7;
        cyc(); cyc(); cyc();
        chk("r7_waw_ready", {31'h0, id_ready}, 32'h0);
        chk("r7_pend", pend_vec, 32'h80);
        chk("r7_infl", {24'h0, inflight}, 32'h3);
        id_valid = 1'b0;
        cyc();
        chk("r7_infl_hold", {24'h0, inflight}, 32'h3);
        chk("r7_stall", {16'h0, stall_cycles}, S0);

        // Issue and retire r9 in the same cycle
        id_valid = 1'b1; id_dst = 5'd9;
        cyc();
        wb_valid = 1'b1; wb_addr = 5'd9;
        #1 chk("r9_ready", {31'h0, id_ready}, 32'h1);
        cyc();
        chk("r9_same_pend", pend_vec, 32'h280);
        chk("r9_same_infl", {24'h0, inflight}, 32'h4);
        id_valid = 1'b0; id_dst_we = 1'b0; id_dst = 5'd0;
        cyc();
        chk("r9_ret_pend", pend_vec, 32'h80);
        chk("r9_ret_infl", {24'h0, inflight}, 32'h3);
        chk("r9_err", {31'h0, err_underflow}, 32'h0);

        // Underflow on r12
        wb_addr = 5'd12;
        cyc();
        wb_valid = 1'b0; wb_addr = 5'd0;
        chk("r12_err", {31'h0, err_underflow}, 32'h1);
        chk("r12_infl", {24'h0, inflight}, 32'h3);
        chk("r12_pend", pend_vec, 32'h80);

        // Four pending registers, then flush with a discarded issue/retire
        id_valid = 1'b1; id_dst_we = 1'b1; id_dst = 5'd1;
        cyc();
        id_dst = 5'd2;
        cyc();
        id_dst = 5'd3;
        cyc();
        id_valid = 1'b0;
        #1 chk("fl_pre_pend", pend_vec, 32'h8e);
        chk("fl_pre_infl", {24'h0, inflight}, 32'h6);
        flush = 1'b1; id_valid = 1'b1; id_dst = 5'd4; wb_valid = 1'b1; wb_addr = 5'd7;
        #1 chk("fl_ready", {31'h0, id_ready}, 32'h0);
        cyc();
        flush = 1'b0; id_valid = 1'b0; id_dst_we = 1'b0; id_dst = 5'd0;
        wb_valid = 1'b0; wb_addr = 5'd0;
        chk("fl_pend", pend_vec, 32'h0);
        chk("fl_infl", {24'h0, inflight}, 32'h0);
        chk("fl_err", {31'h0, err_underflow}, 32'h1);
        chk("fl_stall", {16'h0, stall_cycles}, S0 + 32'd1);

        // Register 0 never stalls and is never counted
        id_valid = 1'b1; id_dst_we = 1'b1;
        #1 chk("r0_ready", {31'h0, id_ready}, 32'h1);
        cyc(); cyc();
        chk("r0_infl", {24'h0, inflight}, 32'h0);
        chk("r0_pend", pend_vec, 32'h0);
        chk("r0_stall", {16'h0, stall_cycles}, S0 + 32'd1);

        // Long hazard on r10 via src2 saturates stall_cycles
        id_dst = 5'd10;
        cyc();
        id_dst_we = 1'b0; id_dst = 5'd0; id_src2 = 5'd10;
        #1 chk("sat_ready", {31'h0, id_ready}, 32'h0);
        repeat (70000) cyc();
        chk("sat_stall", {16'h0, stall_cycles}, 32'hffff);
        chk("sat_pend", pend_vec, 32'h400);
        chk("sat_infl", {24'h0, inflight}, 32'h1);

        // Reset mid-operation beats issue, retire and stall
        reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd10; id_dst_we = 1'b1; id_dst = 5'd11;
        cyc();
        reset = 1'b0; id_valid = 1'b0; id_dst_we = 1'b0; id_dst = 5'd0;
        id_src2 = 5'd0; wb_valid = 1'b0; wb_addr = 5'd0;
        #1 chk("rst2_pend", pend_vec, 32'h0);
        chk("rst2_infl", {24'h0, inflight}, 32'h0);
        chk("rst2_stall", {16'h0, stall_cycles}, 32'h0);
        chk("rst2_err", {31'h0, err_underflow}, 32'h0);
        chk("rst2_ready", {31'h0, id_ready}, 32'h1);

        // Retire to register 0 is ignored
        wb_valid = 1'b1; wb_addr = 5'd0;
        cyc();
        wb_valid = 1'b0;
        chk("wb0_err", {31'h0, err_underflow}, 32'h0);
        chk("wb0_infl", {24'h0, inflight}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: architectural registers tracked; register 0 is never tracked.
REQ-002 Parameter MAX_PEND, default 3: maximum in-flight writes per register; counter width CNT_W = clog2(MAX_PEND+1).
REQ-003 Parameter ADDR_W, default clog2(NUM_REGS): register address width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 id_valid  in  1  decode stage presents an instruction.
REQ-007 id_src1, id_src2  in  ADDR_W each  source register addresses.
REQ-008 id_dst  in  ADDR_W  destination register address.
REQ-009 id_dst_we  in  1  instruction writes id_dst.
REQ-010 id_ready  out  1  instruction may issue this cycle (combinational).
REQ-011 wb_valid  in  1  writeback retires one write this cycle.
REQ-012 wb_addr  in  ADDR_W  register being retired.
REQ-013 flush  in  1  discard all in-flight tracking.
REQ-014 pend_vec  out  NUM_REGS  bit i = 1 when counter i is nonzero (registered).
REQ-015 inflight  out  8  total outstanding writes across all registers (registered).
REQ-016 stall_cycles  out  16  saturating count of cycles with id_valid=1 and id_ready=0.
REQ-017 err_underflow  out  1  sticky: retire seen for a register with counter 0.

Function
REQ-018 Source hazard: id_src1 or id_src2 nonzero with its counter nonzero.
REQ-019 WAW limit: id_dst_we=1, id_dst nonzero, counter[id_dst] == MAX_PEND.
REQ-020 id_ready = !(source hazard or WAW limit) and !flush; id_ready is independent of id_valid.
REQ-021 Issue fires when id_valid and id_ready and id_dst_we and id_dst != 0: counter[id_dst] +1 at next edge.
REQ-022 Retire with wb_valid and wb_addr != 0: counter[wb_addr] -1 at next edge; wb_addr 0 ignored.
REQ-023 Issue and retire to the same register in one cycle: counter unchanged.
REQ-024 Retire to a register with counter 0: counter stays 0, err_underflow set, stays set until reset.
REQ-025 inflight tracks the sum of all counters each cycle (+1 issue, -1 valid retire, net 0 both).
REQ-026 flush: all counters and inflight cleared next edge; same-cycle issue and retire discarded; err_underflow and stall_cycles retained.
REQ-027 stall_cycles increments each cycle id_valid=1 and id_ready=0, saturates at 0xFFFF.
REQ-028 Retire and issue never change counters outside register indices 1..NUM_REGS-1.

Reset
REQ-029 reset: all counters 0, pend_vec 0, inflight 0, stall_cycles 0, err_underflow 0; id_ready=1 from the first post-reset cycle.
REQ-030 reset has priority over flush, issue and retire; reset mid-operation discards all in-flight tracking.

Configuration
REQ-031 Macro SCB_RETIRE_BYPASS_EN defined: a source hazard on register r is suppressed when wb_valid=1, wb_addr=r and counter[r]==1 in the same cycle (same-cycle writeback visible).
REQ-032 Macro SCB_RETIRE_BYPASS_EN undefined: the hazard holds until the counter reads 0 (one extra stall cycle).

Structure
REQ-033 Package scb_pkg holds default NUM_REGS, MAX_PEND, the clog2 helper and the counter-width constant.
REQ-034 Sub-module scb_counter holds one saturating up/down pending counter, instantiated per register 1..NUM_REGS-1.

Verification
REQ-035 Issue dst=5, next cycle src1=5 -> id_ready=0; wb_valid wb_addr=5 -> id_ready=1 same cycle with bypass, one cycle later without.
REQ-036 Three issues to dst=7 with MAX_PEND=3 -> fourth dst=7 issue sees id_ready=0, pend_vec[7]=1, inflight=3.
REQ-037 Counter[9]=1, issue dst=9 and retire 9 same cycle -> counter[9] stays 1, inflight unchanged.
REQ-038 wb_valid wb_addr=12 with counter 0 -> err_underflow=1 next cycle, held through flush, cleared only by reset.
REQ-039 Four registers pending, assert flush -> pend_vec=0, inflight=0 next cycle; stall_cycles retained.
REQ-040 src1=0 and dst=0 issues -> never stall, never counted; id_valid held with hazard 70000 cycles -> stall_cycles=0xFFFF.
